// File: rtl/timer_bank.sv
// timer_bank: CHANNELS independent down-counting timers that share one
// prescaler. Each channel can be loaded and read back. A global pause
// freezes the prescaler and all decrements. Channels stop at zero.
module timer_bank #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned CHANNELS = 2,
  parameter  int unsigned DIV      = 16666,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  input  logic                set,
  input  logic [SEL_W-1:0]    sel,
  input  logic [WIDTH-1:0]    newValue,
  input  logic [SEL_W-1:0]    rdSel,
  output logic [WIDTH-1:0]    rdValue,
  output logic [CHANNELS-1:0] isZero,
  output logic                tick
);

  localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] val_q [CHANNELS];
  logic [WIDTH-1:0] val_d [CHANNELS];

  // Prescaler advance and tick strobe; both are frozen while paused.
  always_comb begin
    tick  = (pre_q == DIV_M1) && !pause && !reset;
    pre_d = pre_q;
    if (!pause) begin
      pre_d = (pre_q == DIV_M1) ? '0 : pre_q + 1'b1;
    end
  end

  // Per-channel next value: a load wins over a decrement for its own channel
  // only. An out-of-range sel matches no channel, so the load is dropped.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      val_d[i] = val_q[i];
      if (set && (sel == SEL_W'(i))) begin
        val_d[i] = newValue;
      end else if (tick && (val_q[i] != '0)) begin
        val_d[i] = val_q[i] - 1'b1;
      end
    end
  end

  // State registers; reset overrides any load or decrement in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        val_q[i] <= '0;
      end
    end else begin
      pre_q <= pre_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        val_q[i] <= val_d[i];
      end
    end
  end

  // Readback mux and zero flags; an out-of-range rdSel reads as zero.
  always_comb begin
    rdValue = '0;
    isZero  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (rdSel == SEL_W'(i)) begin
        rdValue = val_q[i];
      end
      isZero[i] = (val_q[i] == '0);
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank: a directed vector table on a 2-channel DIV=4 bank,
// plus short sequences for pause, reset mid-count, out-of-range select
// (3-channel bank) and the DIV=1 case.
module tb_timer_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instance A: WIDTH=8, CHANNELS=2, DIV=4
  logic       a_reset, a_pause, a_set, a_sel, a_rdSel, a_tick;
  logic [7:0] a_nv, a_rd;
  logic [1:0] a_isz;
  timer_bank #(.WIDTH(8), .CHANNELS(2), .DIV(4)) u_a (
    .clk(clk), .reset(a_reset), .pause(a_pause), .set(a_set), .sel(a_sel),
    .newValue(a_nv), .rdSel(a_rdSel), .rdValue(a_rd), .isZero(a_isz), .tick(a_tick)
  );

  // Instance B: CHANNELS=3 so sel/rdSel=3 is out of range
  logic       b_reset, b_pause, b_set, b_tick;
  logic [1:0] b_sel, b_rdSel;
  logic [7:0] b_nv, b_rd;
  logic [2:0] b_isz;
  timer_bank #(.WIDTH(8), .CHANNELS(3), .DIV(4)) u_b (
    .clk(clk), .reset(b_reset), .pause(b_pause), .set(b_set), .sel(b_sel),
    .newValue(b_nv), .rdSel(b_rdSel), .rdValue(b_rd), .isZero(b_isz), .tick(b_tick)
  );

  // Instance C: DIV=1, tick on every unpaused cycle
  logic       c_reset, c_pause, c_set, c_sel, c_rdSel, c_tick;
  logic [7:0] c_nv, c_rd;
  logic [1:0] c_isz;
  timer_bank #(.WIDTH(8), .CHANNELS(2), .DIV(1)) u_c (
    .clk(clk), .reset(c_reset), .pause(c_pause), .set(c_set), .sel(c_sel),
    .newValue(c_nv), .rdSel(c_rdSel), .rdValue(c_rd), .isZero(c_isz), .tick(c_tick)
  );

  typedef struct {
    logic       set;
    logic       sel;
    logic [7:0] nv;
    logic       rds;
    logic [7:0] erd;
    logic [1:0] ez;
    logic       et;
  } vec_t;

  vec_t vq[$];

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Vectors for instance A, one per clock, starting right after reset.
    // Fields: set, sel, newValue, rdSel | rdValue, isZero, tick
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd0, 2'b11, 1'b0}); // p=0
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd0, 2'b11, 1'b0}); // p=1
    vq.push_back('{1'b1, 1'b0, 8'd3,  1'b0, 8'd0, 2'b11, 1'b0}); // p=2 load ch0=3
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd3, 2'b10, 1'b1}); // p=3 tick 1
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd2, 2'b10, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd2, 2'b10, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd2, 2'b10, 1'b0});
    vq.push_back('{1'b1, 1'b1, 8'd5,  1'b0, 8'd2, 2'b10, 1'b1}); // tick 2 + load ch1=5
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 8'd5, 2'b00, 1'b0}); // ch1=5 not 4
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd1, 2'b00, 1'b0}); // ch0=1
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 8'd5, 2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd1, 2'b00, 1'b1}); // tick 3
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd0, 2'b01, 1'b0}); // ch0 hits 0
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 8'd4, 2'b01, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b1, 8'd4, 2'b01, 1'b0});
    vq.push_back('{1'b0, 1'b0, 8'd0,  1'b0, 8'd0, 2'b01, 1'b1}); // tick 4, no wrap
    vq.push_back('{1'b1, 1'b0, 8'd10, 1'b1, 8'd3, 2'b01, 1'b0}); // load ch0=10

    a_reset = 1'b1; a_pause = 1'b0; a_set = 1'b0; a_sel = 1'b0; a_nv = '0; a_rdSel = 1'b0;
    b_reset = 1'b1; b_pause = 1'b1; b_set = 1'b0; b_sel = '0;   b_nv = '0; b_rdSel = '0;
    c_reset = 1'b1; c_pause = 1'b0; c_set = 1'b0; c_sel = 1'b0; c_nv = '0; c_rdSel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

    // ---- table on instance A ----
    foreach (vq[i]) begin
      a_set = vq[i].set; a_sel = vq[i].sel; a_nv = vq[i].nv; a_rdSel = vq[i].rds;
      @(negedge clk);
      chk($sformatf("vec%0d_rdValue", i), a_rd,   vq[i].erd);
      chk($sformatf("vec%0d_isZero", i),  a_isz,  vq[i].ez);
      chk($sformatf("vec%0d_tick", i),    a_tick, vq[i].et);
      next_cycle();
    end
    a_set = 1'b0; a_rdSel = 1'b0;
    // now: prescaler=1, ch0=10, ch1=3

    // ---- pause for 20 clocks, load ch1=7 during pause ----
    a_pause = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a_set = (k == 10); a_sel = 1'b1; a_nv = 8'd7;
      @(negedge clk);
      chk("pause_tick", a_tick, 0);
      chk("pause_ch0", a_rd, 10);
      next_cycle();
    end
    a_set = 1'b0; a_pause = 1'b0; a_rdSel = 1'b1;
    // prescaler frozen at 1: ticks at the 3rd cycle after release
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("resume_tick", a_tick, (k == 2) ? 1 : 0);
      chk("resume_ch1", a_rd, 7);
      next_cycle();
    end
    chk("resume_ch1_dec", a_rd, 6);
    a_rdSel = 1'b0; #1;
    chk("resume_ch0_dec", a_rd, 9);

    // ---- reset mid-count (prescaler now 0) ----
    a_set = 1'b1; a_sel = 1'b0; a_nv = 8'd200;
    next_cycle();                 // p=1
    a_set = 1'b0;
    @(negedge clk);
    chk("ch0_200", a_rd, 200);
    next_cycle();                 // p=2
    next_cycle();                 // p=3
    a_reset = 1'b1;
    @(negedge clk);
    chk("tick_masked_by_reset", a_tick, 0);
    next_cycle();
    a_reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_reset_tick", a_tick, (k == 3) ? 1 : 0);
      if (k == 0) begin
        chk("post_reset_ch0", a_rd, 0);
        chk("post_reset_isZero", a_isz, 3);
      end
      next_cycle();
    end

    // ---- instance B: out-of-range sel/rdSel (kept paused) ----
    for (int k = 0; k < 4; k++) begin
      b_set = 1'b1; b_sel = 2'(k); b_nv = (k == 3) ? 8'hFF : 8'(8'h11 * (k + 1));
      next_cycle();
    end
    b_set = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_rdSel = 2'(k); #1;
      chk($sformatf("b_rd%0d", k), b_rd, (k == 3) ? 0 : 8'h11 * (k + 1));
    end
    chk("b_isZero", b_isz, 0);
    chk("b_tick_paused", b_tick, 0);

    // ---- instance C: DIV=1 ----
    @(negedge clk);
    chk("c_tick_idle", c_tick, 1);
    next_cycle();
    c_set = 1'b1; c_sel = 1'b0; c_nv = 8'd4;
    next_cycle();
    c_set = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("c_ch0_%0d", k), c_rd, (k < 4) ? 4 - k : 0);
      chk($sformatf("c_isz0_%0d", k), c_isz[0], (k >= 4) ? 1 : 0);
      next_cycle();
    end
    c_pause = 1'b1;
    @(negedge clk);
    chk("c_tick_paused", c_tick, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
